opti_divider: RTL and testbench
===============================

# opti_divider

Q2.14 signed fixed-point divider, the inverse of the Booth/Wallace multiplier in the filter datapath. It computes q = a / b with a multi-cycle radix-2 restoring algorithm under a valid/ready handshake. The IIR coefficient-update path uses it wherever a normalisation or reciprocal is needed. Rounding, saturation bounds and the valid convention match the multiplier.

## Interface
- `Q_FRAC`, 14: fractional bits of operands and result; fixed, not overridable.
- `clk  input  1`: single clock, rising edge.
- `rst_n  input  1`: asynchronous, active-low reset.
- `a  input  16`: signed dividend, Q2.14.
- `b  input  16`: signed divisor, Q2.14.
- `valid_in  input  1`: request; accepted on a rising edge where `valid_in && ready`.
- `ready  output  1`: high only in IDLE; reset value 1.
- `q  output  16`: signed quotient, Q2.14; reset value 0; holds until the next result.
- `valid_out  output  1`: one-cycle pulse when `q` is updated; reset value 0.
- `sat  output  1`: result was clamped (overflow or divide-by-zero); reset 0; updated with `q`.
- `dbz  output  1`: divisor was zero; reset 0; updated with `q`.

## Operation
- States: IDLE, CALC.
- IDLE → CALC on accept:
  - Latch `a` and `b`.
  - Form 17-bit magnitudes |a| and |b|; −2.0 gives magnitude 32768.
  - Record sign = a[15] XOR b[15].
  - Clear the remainder and load the step counter with 15.
- CALC runs exactly 16 cycles, producing one quotient bit per cycle, MSB first:
  - Qm = floor(|a|·2^15 / |b|), 16 bits.
  - Remainder register is 18 bits.
- Pre-check is done at accept and latched: ovf = (|a| ≥ 2·|b|), dbz = (b == 0). The iteration still runs for constant latency, and its result is discarded when ovf or dbz is set.
- Result rule, applied on the last CALC cycle:
  - mag = (Qm + 1) >> 1. This is round-half-up on the magnitude, i.e. half away from zero.
  - q = sign ? −mag : mag, clamped to [0x8000, 0x7FFF].
  - mag = 32768 with a positive sign → 0x7FFF with sat = 1. With a negative sign → 0x8000 with sat = 0.
- Overflow (ovf, b ≠ 0): q = sign ? 0x8000 : 0x7FFF; sat = 1.
- Divide-by-zero: q = a[15] ? 0x8000 : 0x7FFF (so a = 0 gives 0x7FFF); sat = 1, dbz = 1.
- CALC → IDLE on the last CALC cycle. `q`, `sat`, `dbz` and `valid_out` are registered on that same edge.
- `valid_in` while `ready` = 0 is ignored; there is no queuing or back-pressure memory.

## Timing
- Accept at edge E0.
- Quotient bits are produced at E1..E16.
- Result registers at E17; `valid_out` = 1 and `ready` = 1 during the cycle after E17.
- Earliest next accept is E18. Latency is 17 cycles; throughput is 1 result per 18 cycles, constant for every operand class.
- `a` and `b` need to be stable only at the accept edge.
- `valid_out` may be high in the same cycle a new request is accepted. Accepting does not affect the pulse or the value of `q`.
- Reset mid-CALC:
  - Abort immediately; all outputs return to their reset values and `ready` = 1.
  - No `valid_out` is ever generated for the aborted operation.

## Structure
- Shared package `opti_fixed_pkg` holds:
  - `Q_FRAC` = 14, `Q14_MAX` = 16'sh7FFF, `Q14_MIN` = 16'sh8000.
  - The divider state enum (IDLE, CALC).
  - The multiplier also moves to these constants.
- One natural sub-module, `div_restore_step`, which is combinational:
  - Inputs: 18-bit remainder, 17-bit divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
  - The top level holds the FSM, counter, operand/sign registers and the output rounding/saturation.

## Test plan
- a=0x4000 (1.0), b=0x6000 (1.5) → q=0x2AAB (Qm=21845), sat=0, dbz=0, `valid_out` exactly 17 cycles after accept.
- a=0x4000, b=0x8000 (−2.0) → q=0xE000 (−0.5); a=0x8000, b=0x8000 → q=0x4000 (1.0), sat=0.
- a=0x7FFF, b=0x2000 → q=0x7FFF, sat=1; a=0x8000, b=0x4000 → q=0x8000, sat=1.
- a=0xC000, b=0 → q=0x8000, sat=1, dbz=1; a=0, b=0 → q=0x7FFF, dbz=1.
- `valid_in` held high with new operands every cycle for 60 cycles → accepts only at E0, E18, E36, E54; `ready` low in between. Each `q` matches the operands sampled at its own accept edge.
- `rst_n` pulsed low at E8 of an operation → q=0, valid_out=0, sat=0, dbz=0, ready=1. No result pulse appears, and a new request accepted right after reset returns its correct result 17 cycles later.

Source files
------------

// File: rtl/opti_fixed_pkg.sv
// Shared Q2.14 fixed-point constants and types for the filter datapath
// (divider and Booth/Wallace multiplier).
package opti_fixed_pkg;

  localparam int                 Q_FRAC  = 14;
  localparam logic signed [15:0] Q14_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q14_MIN = 16'sh8000;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } div_state_e;

  // Magnitude of a Q2.14 value, widened so that -2.0 maps to 32768.
  function automatic logic [16:0] q14_mag(input logic [15:0] x);
    return x[15] ? ({1'b0, ~x} + 17'd1) : {1'b0, x};
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift in one dividend bit, trial-subtract
// the divisor and keep the difference only when it is non-negative.
module div_restore_step (
  input  logic [17:0] rem_i,
  input  logic [16:0] div_i,
  input  logic        bit_i,
  output logic [17:0] rem_o,
  output logic        q_o
);

  logic [18:0] shifted;
  logic [17:0] diff;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {2'b00, div_i});
  // Truncation is exact whenever the subtraction is kept, since then diff < shifted.
  assign diff    = shifted[17:0] - {1'b0, div_i};
  assign rem_o   = q_o ? diff : shifted[17:0];

endmodule

// File: rtl/opti_divider.sv
// Q2.14 signed divider: 16-step restoring iteration on magnitudes, then
// half-away-from-zero rounding and saturation. Constant 17-cycle latency.
module opti_divider
  import opti_fixed_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        valid_in,
  output logic        ready,
  output logic [15:0] q,
  output logic        valid_out,
  output logic        sat,
  output logic        dbz
);

  localparam int STEPS = Q_FRAC + 2;

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [16:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic        sign_q, sign_d, a_neg_q, a_neg_d;
  logic        ovf_q, ovf_d, zero_q, zero_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] qm_q, qm_d;
  logic [15:0] q_q, q_d;
  logic        sat_q, sat_d, dbz_q, dbz_d, vld_q, vld_d;

  logic [16:0] in_mag_a, in_mag_b;
  logic        first;
  logic [17:0] step_rem_in, step_rem;
  logic        step_bit, step_qbit;
  logic [15:0] rnd_mag;

  assign in_mag_a = q14_mag(a);
  assign in_mag_b = q14_mag(b);

  // The dividend is |a| << 15; its top 16 bits (|a| >> 1) are already below |b|
  // when there is no overflow, so they enter as the partial remainder on the
  // first step together with |a|[0]; every later step brings down a zero.
  assign first       = (cnt_q == 5'(STEPS - 1));
  assign step_rem_in = first ? {2'b00, mag_a_q[16:1]} : rem_q;
  assign step_bit    = first & mag_a_q[0];

  div_restore_step u_step (
    .rem_i (step_rem_in),
    .div_i (mag_b_q),
    .bit_i (step_bit),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  // (Qm + 1) >> 1 without a 17-bit intermediate; at most 32768.
  assign rnd_mag = {1'b0, qm_q[15:1]} + {15'd0, qm_q[0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    sign_d  = sign_q;
    a_neg_d = a_neg_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    rem_d   = rem_q;
    qm_d    = qm_q;
    q_d     = q_q;
    sat_d   = sat_q;
    dbz_d   = dbz_q;
    vld_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          state_d = CALC;
          cnt_d   = 5'(STEPS - 1);
          mag_a_d = in_mag_a;
          mag_b_d = in_mag_b;
          sign_d  = a[15] ^ b[15];
          a_neg_d = a[15];
          ovf_d   = ({1'b0, in_mag_a} >= {in_mag_b, 1'b0});
          zero_d  = (b == 16'd0);
          rem_d   = '0;
          qm_d    = '0;
        end
      end
      CALC: begin
        if (!cnt_q[4]) begin
          rem_d = step_rem;
          qm_d  = {qm_q[14:0], step_qbit};
          cnt_d = cnt_q - 5'd1;
        end else begin
          state_d = IDLE;
          vld_d   = 1'b1;
          if (zero_q) begin
            q_d   = a_neg_q ? Q14_MIN : Q14_MAX;
            sat_d = 1'b1;
            dbz_d = 1'b1;
          end else if (ovf_q) begin
            q_d   = sign_q ? Q14_MIN : Q14_MAX;
            sat_d = 1'b1;
            dbz_d = 1'b0;
          end else if (rnd_mag[15]) begin
            // -2.0 is representable, +2.0 is not.
            q_d   = sign_q ? Q14_MIN : Q14_MAX;
            sat_d = ~sign_q;
            dbz_d = 1'b0;
          end else begin
            q_d   = sign_q ? (16'd0 - rnd_mag) : rnd_mag;
            sat_d = 1'b0;
            dbz_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      sign_q  <= 1'b0;
      a_neg_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      rem_q   <= '0;
      qm_q    <= '0;
      q_q     <= '0;
      sat_q   <= 1'b0;
      dbz_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      sign_q  <= sign_d;
      a_neg_q <= a_neg_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      rem_q   <= rem_d;
      qm_q    <= qm_d;
      q_q     <= q_d;
      sat_q   <= sat_d;
      dbz_q   <= dbz_d;
      vld_q   <= vld_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign q         = q_q;
  assign sat       = sat_q;
  assign dbz       = dbz_q;
  assign valid_out = vld_q;

endmodule

// File: tb/tb_opti_divider.sv
// Scoreboard bench for opti_divider: directed vectors, a saturated request
// stream and a mid-operation reset.
module tb_opti_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a, b, q;
  logic        valid_in, ready, valid_out, sat, dbz;

  always #5 clk = ~clk;

  opti_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .valid_in  (valid_in),
    .ready     (ready),
    .q         (q),
    .valid_out (valid_out),
    .sat       (sat),
    .dbz       (dbz)
  );

  typedef struct {
    logic [15:0] q;
    logic        sat;
    logic        dbz;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic        sat;
    logic        dbz;
  } vec_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference: integer division on magnitudes.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y);
    exp_t   r;
    int     ma, mb, mag;
    longint qm;
    logic   s;
    ma = x[15] ? 65536 - int'(x) : int'(x);
    mb = y[15] ? 65536 - int'(y) : int'(y);
    s  = x[15] ^ y[15];
    r.cyc = 0;
    if (y == 16'd0) begin
      r.q = x[15] ? 16'h8000 : 16'h7FFF; r.sat = 1'b1; r.dbz = 1'b1;
    end else if (ma >= 2 * mb) begin
      r.q = s ? 16'h8000 : 16'h7FFF; r.sat = 1'b1; r.dbz = 1'b0;
    end else begin
      qm  = (longint'(ma) << 15) / longint'(mb);
      mag = int'((qm + 1) / 2);
      r.dbz = 1'b0;
      if (mag == 32768) begin
        r.q = s ? 16'h8000 : 16'h7FFF; r.sat = ~s;
      end else begin
        r.q = s ? 16'(65536 - mag) : 16'(mag); r.sat = 1'b0;
      end
    end
    return r;
  endfunction

  // Monitor: every valid_out pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out actual=1 required=0 q=%0h", q);
      end else begin
        e = sb.pop_front();
        chk("q", q, e.q);
        chk("sat", sat, e.sat);
        chk("dbz", dbz, e.dbz);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [15:0] x, input logic [15:0] y, input exp_t e);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    a = x;
    b = y;
    valid_in = 1'b1;
    e.cyc = cyc + 18;
    sb.push_back(e);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_q"}, q, 16'h0000);
    chk({tag, "_valid_out"}, valid_out, 0);
    chk({tag, "_sat"}, sat, 0);
    chk({tag, "_dbz"}, dbz, 0);
    chk({tag, "_ready"}, ready, 1);
  endtask

  vec_t vt[14];

  initial begin
    exp_t e;
    logic exp_rdy;
    vt = '{
      '{16'h4000, 16'h6000, 16'h2AAB, 1'b0, 1'b0},
      '{16'h4000, 16'h8000, 16'hE000, 1'b0, 1'b0},
      '{16'h8000, 16'h8000, 16'h4000, 1'b0, 1'b0},
      '{16'h7FFF, 16'h2000, 16'h7FFF, 1'b1, 1'b0},
      '{16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0},
      '{16'hC000, 16'h0000, 16'h8000, 1'b1, 1'b1},
      '{16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b1},
      '{16'h4000, 16'hA000, 16'hD555, 1'b0, 1'b0},
      '{16'h0001, 16'h0003, 16'h1555, 1'b0, 1'b0},
      '{16'hFFFF, 16'h0003, 16'hEAAB, 1'b0, 1'b0},
      '{16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0},
      '{16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0},
      '{16'h7FFF, 16'h4000, 16'h7FFF, 1'b0, 1'b0},
      '{16'h8001, 16'h4000, 16'h8001, 1'b0, 1'b0}
    };

    rst_n    = 1'b0;
    valid_in = 1'b0;
    a        = '0;
    b        = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Directed vectors with hand-computed results
    foreach (vt[i]) begin
      e.q   = vt[i].q;
      e.sat = vt[i].sat;
      e.dbz = vt[i].dbz;
      e.cyc = 0;
      send(vt[i].a, vt[i].b, e);
      drain();
    end

    // valid_in held high, new operands every cycle: accepts every 18 cycles
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      exp_rdy = ((k % 18) == 0);
      chk("stream_ready", ready, exp_rdy);
      a = 16'(32'h0800 + k * 32'h137);
      b = 16'(32'h2400 - k * 32'h151);
      valid_in = 1'b1;
      if (exp_rdy) begin
        e = model(a, b);
        e.cyc = cyc + 18;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    drain();

    // Reset at E8 of an operation: aborted request must never report
    @(negedge clk);
    a = 16'h4000;
    b = 16'h6000;
    valid_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("post_reset_q_hold", q, 16'h0000);

    e.q = 16'hD555; e.sat = 1'b0; e.dbz = 1'b0; e.cyc = 0;
    send(16'h4000, 16'hA000, e);
    drain();

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout actual=%0d cycles required=finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
